// File: rtl/uno_pkg.sv
// Card encoding, deck constants and card helper functions shared by the UNO deck.
package uno_pkg;

    typedef enum logic [1:0] {
        COLOR_RED    = 2'd0,
        COLOR_YELLOW = 2'd1,
        COLOR_GREEN  = 2'd2,
        COLOR_BLUE   = 2'd3
    } color_e;

    typedef enum logic [3:0] {
        VAL_NUM0    = 4'd0,
        VAL_NUM9    = 4'd9,
        VAL_SKIP    = 4'd10,
        VAL_REVERSE = 4'd11,
        VAL_DRAW2   = 4'd12,
        VAL_WILD    = 4'd13,
        VAL_WILD4   = 4'd14
    } value_e;

    typedef struct packed {
        logic [1:0] color;
        logic [3:0] value;
    } card_t;

    localparam logic [3:0] CARD_NUM_MAX = 4'd9;
    localparam logic [3:0] CARD_SKIP    = 4'd10;
    localparam logic [3:0] CARD_REVERSE = 4'd11;
    localparam logic [3:0] CARD_DRAW2   = 4'd12;
    localparam logic [3:0] CARD_WILD    = 4'd13;
    localparam logic [3:0] CARD_WILD4   = 4'd14;
    localparam logic [6:0] DECK_SIZE    = 7'd108;

    // Card stored at pool slot idx after a fresh fill: 25 cards per color
    // (one 0, two each of 1..12), then four wilds and four wild-draw-fours.
    function automatic card_t canonical_card(input logic [6:0] idx);
        card_t      c;
        logic [6:0] j;
        c.color = COLOR_RED;
        c.value = 4'd0;
        j       = 7'd0;
        if (idx >= 7'd104) begin
            c.value = CARD_WILD4;
        end else if (idx >= 7'd100) begin
            c.value = CARD_WILD;
        end else begin
            if (idx >= 7'd75) begin
                c.color = COLOR_BLUE;
                j       = idx - 7'd75;
            end else if (idx >= 7'd50) begin
                c.color = COLOR_GREEN;
                j       = idx - 7'd50;
            end else if (idx >= 7'd25) begin
                c.color = COLOR_YELLOW;
                j       = idx - 7'd25;
            end else begin
                c.color = COLOR_RED;
                j       = idx;
            end
            c.value = 4'((j + 7'd1) >> 1);
        end
        return c;
    endfunction

    // Wilds carry the player's chosen color while on the pile; strip it
    // before the card goes back into the pool.
    function automatic card_t normalize_wild(input card_t card);
        card_t r;
        r = card;
        if ((card.value == CARD_WILD) || (card.value == CARD_WILD4)) begin
            r.color = COLOR_RED;
        end else begin
            r.color = card.color;
        end
        return r;
    endfunction

endpackage

// File: rtl/uno_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1).
module uno_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_lfsr
);

    logic [15:0] lfsr_r;
    logic        fb_s;

    assign fb_s   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign o_lfsr = lfsr_r;

    // Load the seed on reset, otherwise shift one step every cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], fb_s};
        end
    end

endmodule

// File: rtl/uno_deck.sv
// UNO card pool and discard pile: fills the pool, deals hands, serves random draws.
module uno_deck
    import uno_pkg::*;
#(
    parameter int          N_PLAYER  = 4,
    parameter int          HAND_INIT = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_init,
    input  logic [N_PLAYER-1:0] i_draw,
    output logic [N_PLAYER-1:0] o_drawn,
    output logic [5:0]          o_card,
    input  logic                i_discard,
    input  logic [5:0]          i_discard_card,
    output logic [5:0]          o_top_card,
    output logic                o_idle,
    output logic                o_empty,
    output logic [6:0]          o_pool_cnt
);

    typedef enum logic [2:0] {
        S_FILL = 3'd0, S_IDLE = 3'd1, S_DISC = 3'd2, S_PICK = 3'd3,
        S_READ = 3'd4, S_SWAP = 3'd5, S_DONE = 3'd6
    } state_e;

    typedef enum logic [1:0] {M_DRAW = 2'd0, M_DEAL = 2'd1, M_FLIP = 2'd2} mode_e;

    localparam logic [7:0] DEAL_TOTAL = 8'(HAND_INIT * N_PLAYER);
    localparam logic [1:0] LAST_P     = 2'(N_PLAYER - 1);

    state_e              state_r;
    mode_e               mode_r;
    logic [6:0]          fill_idx_r, pool_cnt_r, r_r;
    logic [1:0]          cur_p_r;
    logic [7:0]          deal_cnt_r;
    logic [N_PLAYER-1:0] pending_r, o_drawn_r, p_onehot_s;
    logic                disc_pend_r, top_valid_r;
    logic [5:0]          disc_card_r, rd_card_r, rd_last_r;
    logic [5:0]          o_card_r, o_top_card_r;
    logic                o_idle_r, o_empty_r;
    logic [5:0]          mem_r [0:127];

    logic [15:0] lfsr_s;
    logic [6:0]  rnd_s, pool_nxt_s, waddr_s;
    logic [5:0]  wdata_s;
    logic        we_s, pick_v_s, flip_reject_s, unused_lfsr_s;
    logic [1:0]  pick_p_s;

    uno_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_lfsr (lfsr_s)
    );

    assign rnd_s         = lfsr_s[6:0];
    assign unused_lfsr_s = ^lfsr_s[15:7];
    assign p_onehot_s    = {{(N_PLAYER-1){1'b0}}, 1'b1} << cur_p_r;
    assign flip_reject_s = (mode_r == M_FLIP) && (rd_card_r[3:0] > CARD_NUM_MAX);

    assign o_drawn    = o_drawn_r;
    assign o_card     = o_card_r;
    assign o_top_card = o_top_card_r;
    assign o_idle     = o_idle_r;
    assign o_empty    = o_empty_r;
    assign o_pool_cnt = pool_cnt_r;

    // Lowest-index pending draw request wins.
    always_comb begin
        pick_v_s = 1'b0;
        pick_p_s = 2'd0;
        for (int i = N_PLAYER - 1; i >= 0; i--) begin
            if (pending_r[i]) begin
                pick_v_s = 1'b1;
                pick_p_s = 2'(i);
            end else begin
                pick_v_s = pick_v_s;
            end
        end
    end

    // Pool RAM write port and next pool count for each state.
    always_comb begin
        we_s       = 1'b0;
        waddr_s    = 7'd0;
        wdata_s    = 6'd0;
        pool_nxt_s = pool_cnt_r;
        case (state_r)
            S_FILL: begin
                we_s    = 1'b1;
                waddr_s = fill_idx_r;
                wdata_s = canonical_card(fill_idx_r);
                if (fill_idx_r == DECK_SIZE - 7'd1) begin
                    pool_nxt_s = DECK_SIZE;
                end else begin
                    pool_nxt_s = pool_cnt_r;
                end
            end
            S_DISC: begin
                // Before the first flip after reset there is no real top card to return.
                if (top_valid_r) begin
                    we_s       = 1'b1;
                    waddr_s    = pool_cnt_r;
                    wdata_s    = normalize_wild(o_top_card_r);
                    pool_nxt_s = pool_cnt_r + 7'd1;
                end else begin
                    we_s = 1'b0;
                end
            end
            S_SWAP: begin
                // Move the last pool card into the hole left by the drawn one.
                we_s       = 1'b1;
                waddr_s    = r_r;
                wdata_s    = rd_last_r;
                pool_nxt_s = pool_cnt_r - 7'd1;
            end
            S_DONE: begin
                // Action cards cannot open the pile: put them back and redraw.
                if (flip_reject_s) begin
                    we_s       = 1'b1;
                    waddr_s    = pool_cnt_r;
                    wdata_s    = rd_card_r;
                    pool_nxt_s = pool_cnt_r + 7'd1;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Pool RAM: one write port, two registered reads captured in READ.
    always_ff @(posedge i_clk) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
        if (state_r == S_READ) begin
            rd_card_r <= mem_r[r_r];
            rd_last_r <= mem_r[pool_cnt_r - 7'd1];
        end
    end

    // Main controller: request capture, arbitration, draw/deal/discard sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= S_FILL;
            mode_r       <= M_DRAW;
            fill_idx_r   <= 7'd0;
            pool_cnt_r   <= 7'd0;
            r_r          <= 7'd0;
            cur_p_r      <= 2'd0;
            deal_cnt_r   <= 8'd0;
            pending_r    <= {N_PLAYER{1'b0}};
            disc_pend_r  <= 1'b0;
            disc_card_r  <= 6'd0;
            top_valid_r  <= 1'b0;
            o_drawn_r    <= {N_PLAYER{1'b0}};
            o_card_r     <= 6'd0;
            o_top_card_r <= 6'd0;
            o_idle_r     <= 1'b0;
            o_empty_r    <= 1'b0;
        end else begin
            pool_cnt_r <= pool_nxt_s;
            o_empty_r  <= (state_r != S_FILL) && (pool_nxt_s == 7'd0);
            o_drawn_r  <= {N_PLAYER{1'b0}};
            o_idle_r   <= 1'b0;

            if ((state_r == S_DONE) && (mode_r == M_DRAW)) begin
                pending_r <= (pending_r & ~p_onehot_s) | i_draw;
            end else begin
                pending_r <= pending_r | i_draw;
            end

            // A newer discard overwrites an unserved one.
            if (i_discard) begin
                disc_pend_r <= 1'b1;
                disc_card_r <= i_discard_card;
            end else if (state_r == S_DISC) begin
                disc_pend_r <= 1'b0;
            end else begin
                disc_pend_r <= disc_pend_r;
            end

            case (state_r)
                S_FILL: begin
                    fill_idx_r <= fill_idx_r + 7'd1;
                    if (fill_idx_r == DECK_SIZE - 7'd1) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_FILL;
                    end
                end
                S_IDLE: begin
                    if (disc_pend_r) begin
                        state_r <= S_DISC;
                    end else if (i_init) begin
                        mode_r     <= M_DEAL;
                        deal_cnt_r <= DEAL_TOTAL;
                        cur_p_r    <= 2'd0;
                        state_r    <= S_PICK;
                    end else if (pick_v_s && (pool_cnt_r != 7'd0)) begin
                        mode_r  <= M_DRAW;
                        cur_p_r <= pick_p_s;
                        state_r <= S_PICK;
                    end else begin
                        state_r  <= S_IDLE;
                        o_idle_r <= !i_discard && ((pending_r | i_draw) == {N_PLAYER{1'b0}});
                    end
                end
                S_DISC: begin
                    o_top_card_r <= disc_card_r;
                    top_valid_r  <= 1'b1;
                    state_r      <= S_IDLE;
                end
                S_PICK: begin
                    // Rejection sampling keeps the pick uniform over the live pool.
                    if (rnd_s < pool_cnt_r) begin
                        r_r     <= rnd_s;
                        state_r <= S_READ;
                    end else begin
                        state_r <= S_PICK;
                    end
                end
                S_READ: state_r <= S_SWAP;
                S_SWAP: state_r <= S_DONE;
                S_DONE: begin
                    case (mode_r)
                        M_DEAL: begin
                            o_drawn_r  <= p_onehot_s;
                            o_card_r   <= rd_card_r;
                            deal_cnt_r <= deal_cnt_r - 8'd1;
                            state_r    <= S_PICK;
                            if (deal_cnt_r == 8'd1) begin
                                mode_r <= M_FLIP;
                            end else if (cur_p_r == LAST_P) begin
                                cur_p_r <= 2'd0;
                            end else begin
                                cur_p_r <= cur_p_r + 2'd1;
                            end
                        end
                        M_FLIP: begin
                            if (flip_reject_s) begin
                                state_r <= S_PICK;
                            end else begin
                                o_top_card_r <= rd_card_r;
                                top_valid_r  <= 1'b1;
                                state_r      <= S_IDLE;
                            end
                        end
                        default: begin
                            o_drawn_r <= p_onehot_s;
                            o_card_r  <= rd_card_r;
                            state_r   <= S_IDLE;
                        end
                    endcase
                end
                default: state_r <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_uno_deck.sv
// Directed bench for uno_deck with a draw scoreboard checked on every o_drawn pulse.
module tb_uno_deck;

    logic       clk = 1'b0;
    logic       rst, init, disc;
    logic [1:0] draw, drawn;
    logic [5:0] card, disc_card, top;
    logic       idle, empty;
    logic [6:0] pool;

    typedef struct {
        logic [1:0] drawn;
        logic       chk_card;
        logic [5:0] card;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_drawn  = 0;
    int  hist[64];
    int  exp_hist[64];

    uno_deck #(.N_PLAYER(2), .HAND_INIT(7), .LFSR_SEED(16'hACE1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_init         (init),
        .i_draw         (draw),
        .o_drawn        (drawn),
        .o_card         (card),
        .i_discard      (disc),
        .i_discard_card (disc_card),
        .o_top_card     (top),
        .o_idle         (idle),
        .o_empty        (empty),
        .o_pool_cnt     (pool)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [1:0] d, input logic cc, input logic [5:0] c);
        sb_t e;
        e.drawn    = d;
        e.chk_card = cc;
        e.card     = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (idle !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, idle}, 32'd1);
    endtask

    task automatic do_draw(input logic [1:0] mask);
        @(negedge clk);
        draw = mask;
        @(negedge clk);
        draw = 2'b00;
    endtask

    task automatic do_discard(input logic [5:0] c);
        @(negedge clk);
        disc      = 1'b1;
        disc_card = c;
        @(negedge clk);
        disc = 1'b0;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 64; k++) hist[k] = 0;
    endtask

    // Scoreboard: every o_drawn pulse must match the oldest expected draw.
    always @(negedge clk) begin
        if (!rst && drawn != 2'b00) begin
            n_drawn++;
            hist[card]++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_drawn", {30'd0, drawn}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("drawn_port", {30'd0, drawn}, {30'd0, mon_e.drawn});
                if (mon_e.chk_card) chk("drawn_card", {26'd0, card}, {26'd0, mon_e.card});
            end
        end
    end

    initial begin
        int base;
        int n;
        int early;
        rst = 1'b1; init = 1'b0; disc = 1'b0; draw = 2'b00; disc_card = 6'd0;
        clear_hist();
        for (int k = 0; k < 64; k++) exp_hist[k] = 0;
        for (int c = 0; c < 4; c++) begin
            exp_hist[c*16] = 1;
            for (int v = 1; v <= 12; v++) exp_hist[c*16 + v] = 2;
        end
        exp_hist[13] = 4;
        exp_hist[14] = 4;

        // Reset values, then fill
        repeat (3) @(negedge clk);
        chk("rst_drawn", {30'd0, drawn}, 32'd0);
        chk("rst_card",  {26'd0, card},  32'd0);
        chk("rst_top",   {26'd0, top},   32'd0);
        chk("rst_idle",  {31'd0, idle},  32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd0);
        rst = 1'b0;
        wait_idle("fill_idle", 400);
        chk("fill_pool", {25'd0, pool}, 32'd108);
        chk("fill_empty", {31'd0, empty}, 32'd0);

        // Drain the full pool with player 0: histogram must be the canonical deck
        clear_hist();
        for (int i = 0; i < 108; i++) begin
            push(2'b01, 1'b0, 6'd0);
            do_draw(2'b01);
            wait_idle("drain1_idle", 4000);
        end
        chk("drain1_sb_left", sb_q.size(), 32'd0);
        for (int k = 0; k < 64; k++) chk($sformatf("hist_%02h", k), hist[k], exp_hist[k]);
        chk("drain1_empty", {31'd0, empty}, 32'd1);
        chk("drain1_pool", {25'd0, pool}, 32'd0);

        // Empty pool: first discard has no top to return; pending draw stalls
        do_discard(6'b100011);
        wait_idle("disc0_idle", 200);
        chk("disc0_top", {26'd0, top}, {26'd0, 6'b100011});
        chk("disc0_pool", {25'd0, pool}, 32'd0);
        push(2'b10, 1'b1, 6'b100011);
        do_draw(2'b10);
        early = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (drawn != 2'b00) early++;
        end
        chk("empty_no_drawn", early, 32'd0);
        chk("empty_idle_low", {31'd0, idle}, 32'd0);
        do_discard(6'b110101);
        wait_idle("empty_release_idle", 4000);
        chk("empty_release_sb", sb_q.size(), 32'd0);
        chk("empty_release_top", {26'd0, top}, {26'd0, 6'b110101});
        chk("empty_release_pool", {25'd0, pool}, 32'd0);

        // Reset in the middle of a deal
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle("refill_idle", 400);
        chk("refill_pool", {25'd0, pool}, 32'd108);
        for (int i = 0; i < 14; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 6'd0);
        base = n_drawn;
        @(negedge clk); init = 1'b1;
        @(negedge clk); init = 1'b0;
        n = 0;
        while (n_drawn < base + 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("deal_started", (n_drawn >= base + 3) ? 32'd1 : 32'd0, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_drawn", {30'd0, drawn}, 32'd0);
        chk("midrst_card",  {26'd0, card},  32'd0);
        chk("midrst_top",   {26'd0, top},   32'd0);
        chk("midrst_idle",  {31'd0, idle},  32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_idle("midrst_idle_back", 400);
        chk("midrst_pool", {25'd0, pool}, 32'd108);

        // Full deal: 14 alternating pulses, then a number card on top
        for (int i = 0; i < 14; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 6'd0);
        @(negedge clk); init = 1'b1;
        @(negedge clk); init = 1'b0;
        wait_idle("deal_idle", 6000);
        chk("deal_sb_left", sb_q.size(), 32'd0);
        chk("deal_top_number", (top[3:0] <= 4'd9) ? 32'd1 : 32'd0, 32'd1);
        chk("deal_pool", {25'd0, pool}, 32'd93);
        chk("deal_idle_high", {31'd0, idle}, 32'd1);

        // Two discards: a yellow-colored wild, then red 8
        do_discard(6'b011101);
        wait_idle("disc1_idle", 200);
        chk("disc1_pool", {25'd0, pool}, 32'd94);
        do_discard(6'b001000);
        wait_idle("disc2_idle", 200);
        chk("disc2_top", {26'd0, top}, {26'd0, 6'b001000});
        chk("disc2_pool", {25'd0, pool}, 32'd95);

        // Simultaneous requests: player 0 served before player 1
        clear_hist();
        push(2'b01, 1'b0, 6'd0);
        push(2'b10, 1'b0, 6'd0);
        do_draw(2'b11);
        wait_idle("dual_idle", 8000);
        chk("dual_sb_left", sb_q.size(), 32'd0);
        chk("dual_pool", {25'd0, pool}, 32'd93);

        // Drain: returned wild comes back with its color cleared
        for (int i = 0; i < 93; i++) begin
            push(2'b01, 1'b0, 6'd0);
            do_draw(2'b01);
            wait_idle("drain2_idle", 4000);
        end
        chk("drain2_sb_left", sb_q.size(), 32'd0);
        chk("wild_returned", (hist[6'b001101] > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("wild_color_cleared", hist[6'b011101], 32'd0);
        chk("drain2_empty", {31'd0, empty}, 32'd1);
        chk("drain2_pool", {25'd0, pool}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uno_deck.md
Name: uno_deck

Overview:
- Card source and discard pile for the UNO game: the responder to each player's draw/play interface.
- Holds the 108-card pool in an internal RAM, deals the opening hands, and serves one random card per draw request.
- Tracks the top discard card and returns superseded discards to the pool.
- Players wait on o_idle before issuing their next request.

Parameters:
- N_PLAYER, 4, number of player ports (2..4)
- HAND_INIT, 7, cards dealt to each player on i_init
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset (must be non-zero)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_init  in  1  pulse: deal opening hands, then flip the first top card
- i_draw  in  N_PLAYER  per-player one-cycle request for one card
- o_drawn  out  N_PLAYER  one-cycle pulse; o_card is valid for that player
- o_card  out  6  drawn card {color[1:0], value[3:0]}
- i_discard  in  1  pulse: i_discard_card becomes the top card
- i_discard_card  in  6  played card; for wilds the color field holds the chosen color
- o_top_card  out  6  current top discard
- o_idle  out  1  FSM in IDLE with no pending request
- o_empty  out  1  pool count == 0
- o_pool_cnt  out  7  cards currently in the pool

Behaviour:
- Reset and clock: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Card encoding:
  - color 00 red, 01 yellow, 10 green, 11 blue.
  - value 0-9 number, 10 skip, 11 reverse, 12 draw-two, 13 wild, 14 wild-draw-four.
  - Canonical deck per color: one 0; two each of 1-9, skip, reverse, draw-two (25 per color).
  - Plus 4 wild and 4 wild-draw-four, stored with color 00. Total 108.
- Reset values:
  - o_drawn=0, o_card=0, o_top_card=0, o_idle=0, o_empty=0, pending=0.
  - LFSR=LFSR_SEED; FSM enters FILL.
  - Reset during any state aborts that operation and refills the pool.
- FILL: writes canonical card k to mem[k], one per cycle, for k=0..107. Then o_pool_cnt=108 and the FSM goes to IDLE (o_idle=1 from the next cycle).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle; r = lfsr[6:0].
- Pending requests:
  - i_draw bits are OR'd into pending[] in any state.
  - i_discard latches into a one-deep register. A second discard before o_idle returns is a protocol violation and overwrites the first.
- IDLE arbitration priority: reset > pending discard > deal (i_init) > pending draw, lowest player index first.
- DISCARD (1 cycle):
  - Old top, with color forced to 00 if its value is 13 or 14, is written to mem[pool_cnt]; pool_cnt+1.
  - o_top_card <= i_discard_card.
  - When o_top_card==0 after reset with no flip yet, nothing is returned.
- DRAW sequence PICK -> READ -> SWAP -> DONE:
  - PICK: accept r if r < pool_cnt, otherwise stay in PICK next cycle (rejection sampling).
  - READ: registered RAM read of mem[r].
  - SWAP: mem[r] <= mem[pool_cnt-1]; pool_cnt-1.
  - DONE: o_drawn[p]=1 for one cycle, o_card held until the next draw; clear pending[p].
  - Latency is at least 4 cycles from request; the bench must not assume a fixed value.
- Empty pool: draw requests stay pending and o_idle stays 0. A draw starts once a discard raises pool_cnt.
- DEAL:
  - Issues HAND_INIT x N_PLAYER internal draws, round-robin p0,p1,...; each produces an o_drawn pulse.
  - Then draws the top card. If its value > 9, it is written back (pool_cnt restored) and the top card is redrawn.
  - Otherwise o_top_card = that card. Returns to IDLE.
  - i_init outside IDLE is ignored.

Decomposition:
- Package uno_pkg:
  - color/value enums and the 6-bit card_t
  - CARD_SKIP/REVERSE/DRAW2/WILD/WILD4 constants and DECK_SIZE=108
  - function canonical_card(idx)
  - function normalize_wild(card)
- Sub-module uno_lfsr16: enable-free, seed parameter, 16-bit output. The RAM is inferred inline.

Test Plan:
1. Reset, wait o_idle; 108 sequential i_draw[0] pulses with no discards -> card histogram equals the canonical deck (red 0 x1, red 5 x2, value 13 x4 color 00, ...). o_empty=1 and o_pool_cnt=0 after the last pulse.
2. N_PLAYER=2, i_init -> 14 o_drawn pulses alternating [0],[1], then o_top_card value ≤9, o_pool_cnt=93, o_idle=1.
3. After init, i_discard 6'b011101 then i_discard 6'b001000 -> o_top_card=001000. o_pool_cnt increases by 2 in total over the two discards. Draining the pool yields 001101 but never 011101.
4. i_draw=2'b11 in the same cycle -> o_drawn[0] pulses strictly before o_drawn[1], with two distinct pool decrements.
5. Pool empty, i_draw[1] -> no o_drawn for 50 cycles and o_idle=0. Then i_discard -> o_drawn[1] pulses afterward.
6. Assert i_rst during a DEAL -> all outputs return to reset values, and o_pool_cnt=108 once FILL completes.
